mxv_vector_load_sequencer: RTL and testbench

//   Sequences loading of VECTOR_SIZE-word rows into the MxV word shift register for the

---
 rtl/mxv_vector_load_sequencer.sv | 132 +++++++++++++
 tb/tb_mxv_vector_load_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mxv_vector_load_sequencer.sv
// Row-load sequencer for the MxV multiplier: streams VECTOR_SIZE words per row into the
// word shift register, hands each full row to the MAC stage, repeats for num_rows rows.
module mxv_vector_load_sequencer #(
  parameter  int WORD_LENGTH = 8,
  parameter  int VECTOR_SIZE = 8,
  parameter  int ROW_W       = 8,
  localparam int CNT_W       = $clog2(VECTOR_SIZE)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [ROW_W-1:0]       num_rows,
  input  logic                   in_valid,
  input  logic [WORD_LENGTH-1:0] in_data,
  output logic                   in_ready,
  output logic                   sr_shift_en,
  output logic                   sr_clear,
  output logic [WORD_LENGTH-1:0] sr_data,
  output logic                   vec_valid,
  input  logic                   vec_ack,
  output logic [ROW_W-1:0]       row_idx,
  output logic [CNT_W-1:0]       word_cnt,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_DONE
  } state_t;

  state_t           state, state_n;
  logic [ROW_W-1:0] rows_reg, rows_n;
  logic [ROW_W-1:0] row_n;
  logic [CNT_W-1:0] cnt_n;
  logic             done_n;
  logic             abort_clr, abort_clr_n;
  logic             accept;
  logic             last_word;
  logic             last_row;

  assign accept    = in_valid & (state == S_LOAD);
  assign last_word = (word_cnt == CNT_W'(VECTOR_SIZE - 1));
  assign last_row  = (row_idx == rows_reg - ROW_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      rows_reg  <= '0;
      row_idx   <= '0;
      word_cnt  <= '0;
      done      <= 1'b0;
      abort_clr <= 1'b0;
    end else begin
      state     <= state_n;
      rows_reg  <= rows_n;
      row_idx   <= row_n;
      word_cnt  <= cnt_n;
      done      <= done_n;
      abort_clr <= abort_clr_n;
    end
  end

  always_comb begin
    state_n     = state;
    rows_n      = rows_reg;
    row_n       = row_idx;
    cnt_n       = word_cnt;
    done_n      = 1'b0;
    abort_clr_n = 1'b0;
    if (abort) begin
      // Abort lands straight in IDLE; the shift register clear is issued from IDLE
      // on the following cycle via abort_clr instead of visiting CLEAR.
      state_n     = S_IDLE;
      row_n       = '0;
      cnt_n       = '0;
      abort_clr_n = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (num_rows != '0) begin
              rows_n  = num_rows;
              row_n   = '0;
              state_n = S_CLEAR;
            end else begin
              done_n = 1'b1;
            end
          end
        end
        S_CLEAR: begin
          cnt_n   = '0;
          state_n = S_LOAD;
        end
        S_LOAD: begin
          if (accept) begin
            if (last_word) begin
              cnt_n   = '0;
              state_n = S_DONE;
            end else begin
              cnt_n = word_cnt + CNT_W'(1);
            end
          end
        end
        S_DONE: begin
          if (vec_ack) begin
            if (last_row) begin
              row_n   = '0;
              done_n  = 1'b1;
              state_n = S_IDLE;
            end else begin
              row_n   = row_idx + ROW_W'(1);
              state_n = S_CLEAR;
            end
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  assign in_ready    = (state == S_LOAD);
  assign sr_shift_en = in_valid & in_ready;
  assign sr_data     = in_data;
  assign sr_clear    = (state == S_CLEAR) | abort_clr;
  assign vec_valid   = (state == S_DONE);
  assign busy        = (state != S_IDLE);

endmodule

// File: tb/tb_mxv_vector_load_sequencer.sv
// Scoreboard bench for mxv_vector_load_sequencer: stimulus pushes expected strobes/events,
// a negedge monitor pops and compares them as the DUT raises them.
module tb_mxv_vector_load_sequencer;

  localparam int WL = 8;
  localparam int VS = 8;
  localparam int RW = 8;
  localparam int CW = $clog2(VS);

  localparam int EV_CLEAR = 0;
  localparam int EV_SHIFT = 1;
  localparam int EV_VEC   = 2;
  localparam int EV_DONE  = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [RW-1:0] num_rows = '0;
  logic          in_valid = 1'b0;
  logic [WL-1:0] in_data = '0;
  logic          in_ready;
  logic          sr_shift_en;
  logic          sr_clear;
  logic [WL-1:0] sr_data;
  logic          vec_valid;
  logic          vec_ack = 1'b0;
  logic [RW-1:0] row_idx;
  logic [CW-1:0] word_cnt;
  logic          busy;
  logic          done;

  mxv_vector_load_sequencer #(
    .WORD_LENGTH(WL),
    .VECTOR_SIZE(VS),
    .ROW_W(RW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .abort(abort),
    .num_rows(num_rows),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .sr_shift_en(sr_shift_en),
    .sr_clear(sr_clear),
    .sr_data(sr_data),
    .vec_valid(vec_valid),
    .vec_ack(vec_ack),
    .row_idx(row_idx),
    .word_cnt(word_cnt),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int row;
    int cnt;
    int data;
  } ev_t;

  ev_t q[$];
  int  tests = 0;
  int  fails = 0;
  logic vv_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int kind, input int row, input int cnt, input int data);
    ev_t e;
    e.kind = kind; e.row = row; e.cnt = cnt; e.data = data;
    q.push_back(e);
  endtask

  task automatic mon_evt(input int kind);
    ev_t e;
    if (q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_event: got kind %0d, expected no event (t=%0t)", kind, $time);
    end else begin
      e = q.pop_front();
      chk("event_kind", kind, e.kind);
      if (kind == e.kind) begin
        case (kind)
          EV_SHIFT: begin
            chk("shift_data", sr_data, e.data);
            chk("shift_row", row_idx, e.row);
            chk("shift_cnt", word_cnt, e.cnt);
          end
          EV_CLEAR: chk("clear_row", row_idx, e.row);
          EV_VEC:   chk("vec_row", row_idx, e.row);
          default:  chk("done_busy", busy, 0);
        endcase
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (sr_clear) mon_evt(EV_CLEAR);
      if (sr_shift_en) mon_evt(EV_SHIFT);
      if (vec_valid && !vv_prev) mon_evt(EV_VEC);
      if (done) mon_evt(EV_DONE);
    end
    vv_prev = vec_valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", in_ready, 1);
  endtask

  // abort_row/abort_word < 0 disables the abort; poke drives start/num_rows/vec_ack mid-job
  task automatic run_job(input int rows, input bit gaps, input int hold,
                         input int abort_row, input int abort_word, input bit poke);
    int data;
    push(EV_CLEAR, 0, 0, 0);
    start = 1'b1;
    num_rows = RW'(rows);
    step();
    start = 1'b0;
    chk("start_sr_clear", sr_clear, 1);
    chk("start_busy", busy, 1);
    chk("start_in_ready", in_ready, 0);
    for (int r = 0; r < rows; r++) begin
      wait_ready();
      chk("load_row_idx", row_idx, r);
      for (int w = 0; w < VS; w++) begin
        if (r == abort_row && w == abort_word) begin
          push(EV_CLEAR, 0, 0, 0);
          in_valid = 1'b0;
          abort = 1'b1;
          step();
          abort = 1'b0;
          chk("abort_busy", busy, 0);
          chk("abort_in_ready", in_ready, 0);
          chk("abort_word_cnt", word_cnt, 0);
          chk("abort_row_idx", row_idx, 0);
          chk("abort_sr_clear", sr_clear, 1);
          step();
          chk("abort_clear_once", sr_clear, 0);
          chk("abort_no_done", done, 0);
          return;
        end
        data = (r << 4) | (w + 1);
        if (gaps) begin
          in_valid = 1'b0;
          if (poke && w == 2) begin
            start = 1'b1;
            num_rows = RW'(5);
            vec_ack = 1'b1;
          end
          step();
          start = 1'b0;
          vec_ack = 1'b0;
          chk("gap_word_cnt", word_cnt, w);
        end
        push(EV_SHIFT, r, w, data);
        in_valid = 1'b1;
        in_data = WL'(data);
        step();
      end
      in_valid = 1'b0;
      push(EV_VEC, r, 0, 0);
      chk("vec_valid_after_last", vec_valid, 1);
      for (int h = 0; h < hold; h++) begin
        in_valid = 1'b1;
        in_data = 8'hFF;
        #1;
        chk("hold_vec_valid", vec_valid, 1);
        chk("hold_in_ready", in_ready, 0);
        chk("hold_no_shift", sr_shift_en, 0);
        step();
      end
      in_valid = 1'b0;
      if (r == rows - 1) push(EV_DONE, 0, 0, 0);
      else push(EV_CLEAR, r + 1, 0, 0);
      vec_ack = 1'b1;
      step();
      vec_ack = 1'b0;
      if (r == rows - 1) begin
        chk("ack_done", done, 1);
        chk("ack_busy", busy, 0);
      end else begin
        chk("ack_next_clear", sr_clear, 1);
        chk("ack_next_row", row_idx, r + 1);
      end
    end
    step();
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    step();
    step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sr_clear", sr_clear, 0);
    chk("rst_vec_valid", vec_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_row_idx", row_idx, 0);
    chk("rst_word_cnt", word_cnt, 0);
    reset = 1'b1;
    step();

    run_job(1, 1'b0, 0, -1, -1, 1'b0);
    run_job(3, 1'b1, 0, -1, -1, 1'b1);
    run_job(1, 1'b0, 20, -1, -1, 1'b0);
    run_job(3, 1'b0, 0, 1, 5, 1'b0);
    run_job(2, 1'b0, 0, -1, -1, 1'b0);

    push(EV_DONE, 0, 0, 0);
    start = 1'b1;
    num_rows = '0;
    step();
    start = 1'b0;
    chk("zero_rows_done", done, 1);
    chk("zero_rows_no_clear", sr_clear, 0);
    chk("zero_rows_busy", busy, 0);
    step();
    chk("zero_rows_done_pulse", done, 0);

    push(EV_CLEAR, 0, 0, 0);
    start = 1'b1;
    num_rows = RW'(2);
    step();
    start = 1'b0;
    wait_ready();
    for (int w = 0; w < 3; w++) begin
      push(EV_SHIFT, 0, w, 8'hA0 + w);
      in_valid = 1'b1;
      in_data = WL'(8'hA0 + w);
      step();
    end
    in_valid = 1'b0;
    chk("pre_reset_word_cnt", word_cnt, 3);
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_word_cnt", word_cnt, 0);
    chk("mid_rst_row_idx", row_idx, 0);
    chk("mid_rst_sr_clear", sr_clear, 0);
    chk("mid_rst_vec_valid", vec_valid, 0);
    step();
    step();
    reset = 1'b1;
    step();
    run_job(1, 1'b0, 0, -1, -1, 1'b0);

    step();
    step();
    chk("scoreboard_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
